// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package nsa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_cla.sv
// Combinational 4-bit carry-lookahead slice; also exposes the carry into bit 3
// so the caller can derive signed overflow on the most significant nibble.
module nibble_cla
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c3
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is a flat function of g/p/ci, so there is no ripple inside the slice.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c;
  assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single CLA slice.
// Optional subtract mode is enabled by defining NSA_SUB_EN (adds the `sub` port).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NNIB  = WIDTH / NIB_W;
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic             creg_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, ovf_reg;

  logic             accept;
  logic             last_nib;
  logic [WIDTH-1:0] b_in;
  logic             c_init;
  logic [NIB_W-1:0] x_nib, y_nib, s_nib;
  logic             slice_co, slice_c3;

  assign accept   = in_valid && (state_reg == S_IDLE);
  assign last_nib = (idx_reg == LAST_IDX);

`ifdef NSA_SUB_EN
  // a - b = a + ~b + 1; cin has no meaning while subtracting.
  assign b_in   = sub ? ~b : b;
  assign c_init = sub ? 1'b1 : cin;
`else
  assign b_in   = b;
  assign c_init = cin;
`endif

  assign x_nib = NIB_W'(a_reg >> (int'(idx_reg) * NIB_W));
  assign y_nib = NIB_W'(b_reg >> (int'(idx_reg) * NIB_W));

  nibble_cla u_cla (
    .x  (x_nib),
    .y  (y_nib),
    .ci (creg_reg),
    .s  (s_nib),
    .co (slice_co),
    .c3 (slice_c3)
  );

  for (genvar gi = 0; gi < NNIB; gi++) begin : g_sum_nib
    assign sum_next[gi*NIB_W +: NIB_W] =
      ((state_reg == S_RUN) && (idx_reg == IDX_W'(gi))) ? s_nib : sum_reg[gi*NIB_W +: NIB_W];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (in_valid) state_next = S_RUN;
      S_RUN:   if (last_nib) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg  <= '0;
      creg_reg <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      sum_reg <= sum_next;
      if (accept) begin
        a_reg    <= a;
        b_reg    <= b_in;
        creg_reg <= c_init;
        idx_reg  <= '0;
      end else if (state_reg == S_RUN) begin
        creg_reg <= slice_co;
        idx_reg  <= idx_reg + IDX_W'(1);
        if (last_nib) begin
          cout_reg <= slice_co;
          ovf_reg  <= slice_c3 ^ slice_co;
        end
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16); subtract
// vectors are included when NSA_SUB_EN is defined.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NNIB  = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NSA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Present one operand set, wait (bounded) for out_valid; result left in DONE.
  task automatic start_and_wait(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                input logic tcin, input logic tsub, output int lat);
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tcin, input logic tsub, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo);
    int lat;
    start_and_wait(ta, tb_, tcin, tsub, lat);
    $display("txn %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             name, ta, tb_, tcin, tsub, sum, cout, ovf, lat);
    total++;
    if (lat !== NNIB) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, NNIB); end
    total++;
    if (sum !== es) begin bad++; $display("FAIL %s sum: got %h want %h", name, sum, es); end
    total++;
    if (cout !== ec) begin bad++; $display("FAIL %s cout: got %0d want %0d", name, cout, ec); end
    total++;
    if (ovf !== eo) begin bad++; $display("FAIL %s ovf: got %0d want %0d", name, ovf, eo); end
    release_result();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL %s release: in_ready=%0d out_valid=%0d want 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("txn reset: in_ready=%0d out_valid=%0d sum=%h", in_ready, out_valid, sum);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset handshake: in_ready=%0d out_valid=%0d want 1/0", in_ready, out_valid);
    end
    total++;
    if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++; $display("FAIL reset outputs: sum=%h cout=%0d ovf=%0d want 0/0/0", sum, cout, ovf);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add();
    check_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    check_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check_op("add_7fff_cin",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    check_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    check_op("add_00ff_0f01", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    int lat;
    start_and_wait(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    $display("txn stall: sum=%h lat=%0d", sum, lat);
    @(negedge clk);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h3333) begin
        bad++;
        $display("FAIL stall cycle %0d: out_valid=%0d in_ready=%0d sum=%h want 1/0/3333",
                 i, out_valid, in_ready, sum);
      end
    end
    in_valid = 1'b0;
    release_result();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h3333) begin
      bad++;
      $display("FAIL stall release: in_ready=%0d out_valid=%0d sum=%h want 1/0/3333", in_ready, out_valid, sum);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;           // accept
    in_valid = 1'b0;
    @(posedge clk); #1;           // first RUN nibble done
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn abort: in_ready=%0d out_valid=%0d sum=%h", in_ready, out_valid, sum);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000) begin
      bad++;
      $display("FAIL abort: in_ready=%0d out_valid=%0d sum=%h want 1/0/0000", in_ready, out_valid, sum);
    end
    check_op("after_abort", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_first",  16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    check_op("b2b_second", 16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0);
  endtask

`ifdef NSA_SUB_EN
  task automatic test_sub();
    check_op("sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check_op("sub_7_5",       16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    check_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_abort();
    test_back_to_back();
`ifdef NSA_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
